rd_pntrs_and_empty: RTL and testbench

Read-side pointer and empty-flag logic of the dual-clock FIFO, running entirely in the read clock domain. Synchronises the Gray-coded write pointer from the write domain and maintains the binary read pointer. Generates the registered empty flag and read-side used-word count, and exports a registered Gray read pointer for the write domain to use in its full computation. Instantiated once in the FIFO top level, beside the RAM and the write-side pointer/full logic.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/rd_pntrs_and_empty_if.sv | 32 +++
 rtl/gray_sync.sv | 30 +++
 rtl/rd_pntrs_and_empty.sv | 70 +++++++
 tb/tb_rd_pntrs_and_empty.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: Gray conversion and synchroniser depth.
// Define RD_SYNC_3FF_EN for a 3-stage write-pointer synchroniser.
package fifo_pkg;

  localparam int MAX_W = 32;

`ifdef RD_SYNC_3FF_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // Width-generic through zero extension; callers cast to their width.
  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_pntrs_and_empty_if.sv
// Read-side pointer bundle between the FIFO top and rd_pntrs_and_empty.
// master drives requests and the write pointer; slave returns flags.
interface rd_pntrs_and_empty_if #(
  parameter int AWIDTH = 4
);

  logic              rd_req_i;
  logic [AWIDTH:0]   wr_pntr_gray_i;
  logic [AWIDTH-1:0] rd_pntr_o;
  logic [AWIDTH:0]   rd_pntr_gray_wr_o;
  logic              rd_empty_o;
  logic [AWIDTH-1:0] rd_usedw_o;

  modport master (
    output rd_req_i,
    output wr_pntr_gray_i,
    input  rd_pntr_o,
    input  rd_pntr_gray_wr_o,
    input  rd_empty_o,
    input  rd_usedw_o
  );

  modport slave (
    input  rd_req_i,
    input  wr_pntr_gray_i,
    output rd_pntr_o,
    output rd_pntr_gray_wr_o,
    output rd_empty_o,
    output rd_usedw_o
  );

endinterface

// File: rtl/gray_sync.sv
// N-stage flop chain for crossing a Gray pointer into another clock.
// Shared by both FIFO sides; resets to zero asynchronously.
module gray_sync #(
  parameter int W = 5,
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         aclr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q [N];

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      for (int i = 0; i < N; i++) begin
        q[i] <= '0;
      end
    end else begin
      q[0] <= d_i;
      for (int i = 1; i < N; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign q_o = q[N-1];

endmodule

// File: rtl/rd_pntrs_and_empty.sv
// Read-domain pointer, empty flag and used-word count of the dual-clock FIFO.
// RD_SYNC_3FF_EN selects a 3-stage write-pointer synchroniser.
module rd_pntrs_and_empty
  import fifo_pkg::*;
#(
  parameter int AWIDTH = 4
) (
  input  logic                  rd_clk_i,
  input  logic                  aclr_i,
  rd_pntrs_and_empty_if.slave   bus
);

  localparam int PW = AWIDTH + 1;

  logic [AWIDTH:0]   rd_pntr_bin;
  logic [AWIDTH:0]   rd_pntr_bin_next;
  logic [AWIDTH:0]   rd_gray_next;
  logic [AWIDTH:0]   rd_gray_q;
  logic [AWIDTH:0]   wr_gray_sync;
  logic [AWIDTH:0]   wr_bin_sync;
  logic [AWIDTH-1:0] usedw_next;
  logic [AWIDTH-1:0] usedw_q;
  logic              empty_q;
  logic              rd_ok;

  gray_sync #(
    .W (PW),
    .N (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i  (rd_clk_i),
    .aclr_i (aclr_i),
    .d_i    (bus.wr_pntr_gray_i),
    .q_o    (wr_gray_sync)
  );

  assign rd_ok = bus.rd_req_i & ~empty_q;

  assign rd_pntr_bin_next =
    rd_pntr_bin + PW'(rd_ok);

  assign rd_gray_next =
    PW'(bin2gray(MAX_W'(rd_pntr_bin_next)));

  assign wr_bin_sync =
    PW'(gray2bin(MAX_W'(wr_gray_sync)));

  // A full FIFO wraps to 0 here; empty_q disambiguates.
  assign usedw_next =
    AWIDTH'(wr_bin_sync - rd_pntr_bin_next);

  always_ff @(posedge rd_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      rd_pntr_bin <= '0;
      rd_gray_q   <= '0;
      empty_q     <= 1'b1;
      usedw_q     <= '0;
    end else begin
      rd_pntr_bin <= rd_pntr_bin_next;
      rd_gray_q   <= rd_gray_next;
      empty_q     <= (rd_gray_next == wr_gray_sync);
      usedw_q     <= usedw_next;
    end
  end

  assign bus.rd_pntr_o         = rd_pntr_bin[AWIDTH-1:0];
  assign bus.rd_pntr_gray_wr_o = rd_gray_q;
  assign bus.rd_empty_o        = empty_q;
  assign bus.rd_usedw_o        = usedw_q;

endmodule

// File: tb/tb_rd_pntrs_and_empty.sv
// Randomised and directed bench for rd_pntrs_and_empty (AWIDTH=4).
// Reference model: write count becomes visible S edges after it is applied.
module tb_rd_pntrs_and_empty;

`ifdef RD_SYNC_3FF_EN
  localparam int S = 3;
`else
  localparam int S = 2;
`endif

  logic clk = 1'b0;
  logic aclr = 1'b1;

  always #5 clk = ~clk;

  rd_pntrs_and_empty_if #(.AWIDTH(4)) bus();

  rd_pntrs_and_empty #(.AWIDTH(4)) dut (
    .rd_clk_i (clk),
    .aclr_i   (aclr),
    .bus      (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_wr;
  int m_rd;
  int m_usedw;
  bit m_empty;
  int hist[$];

  logic [13:0] obs;
  logic [13:0] exp_v;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [13:0] model_vec();
    return {4'(m_rd % 16), to_gray(m_rd), m_empty, 4'(m_usedw)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.rd_pntr_o, bus.rd_pntr_gray_wr_o,
            bus.rd_empty_o, bus.rd_usedw_o};
  endfunction

  task automatic set_wr(input int b);
    m_wr = b % 32;
    bus.wr_pntr_gray_i = to_gray(m_wr);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_front(0);
    m_rd = 0;
    m_empty = 1'b1;
    m_usedw = 0;
  endtask

  task automatic edge_model();
    int vis;
    bit do_rd;
    @(posedge clk);
    vis = hist.pop_back();
    hist.push_front(m_wr);
    do_rd = bus.rd_req_i && !m_empty;
    m_rd = (m_rd + int'(do_rd)) % 32;
    m_empty = (m_rd == vis);
    m_usedw = ((vis - m_rd + 32) % 32) % 16;
    #1;
  endtask

  task automatic pulse_aclr(input int wr_hold);
    #2;
    aclr = 1'b1;
    #1;
    obs = dut_vec();
    n_checks++;
    if (obs !== 14'h0010) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, 14'h0010);
    end
    model_reset();
    set_wr(wr_hold);
    @(posedge clk);
    #3;
    aclr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.rd_req_i = 1'b0;
    set_wr(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    repeat (2) edge_model();
    pulse_aclr(0);
  endtask

  task automatic test_latency();
    pulse_aclr(0);
    @(posedge clk);
    #1;
    hist.pop_back();
    hist.push_front(m_wr);
    set_wr(1);
    for (int e = 1; e <= S + 1; e++) begin
      edge_model();
      exp_v = {4'd0, 5'd0, (e <= S), (e <= S) ? 4'd0 : 4'd1};
      obs = dut_vec();
      n_checks++;
      if (obs !== exp_v || obs !== model_vec()) begin
        n_errors++;
        $display("FAIL latency e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_single_read();
    pulse_aclr(0);
    set_wr(1);
    repeat (S + 1) edge_model();
    bus.rd_req_i = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      edge_model();
      exp_v = {4'd1, 5'b00001, 1'b1, 4'd0};
      obs = dut_vec();
      n_checks++;
      if (obs !== exp_v || obs !== model_vec()) begin
        n_errors++;
        $display("FAIL single_read e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    bus.rd_req_i = 1'b0;
  endtask

  task automatic test_full_wrap();
    pulse_aclr(0);
    set_wr(16);
    repeat (S + 1) edge_model();
    obs = dut_vec();
    n_checks++;
    if (obs !== {4'd0, 5'd0, 1'b0, 4'd0}) begin
      n_errors++;
      $display("FAIL full_count got=%h exp=%h", obs, 14'h0);
    end
    bus.rd_req_i = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      edge_model();
      exp_v = {4'((e) % 16), to_gray(e), (e == 16), 4'((16 - e) % 16)};
      obs = dut_vec();
      n_checks++;
      if (obs !== exp_v || obs !== model_vec()) begin
        n_errors++;
        $display("FAIL full_wrap e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    bus.rd_req_i = 1'b0;
  endtask

  task automatic test_reset_burst();
    pulse_aclr(0);
    set_wr(8);
    repeat (S + 1) edge_model();
    bus.rd_req_i = 1'b1;
    repeat (3) edge_model();
    pulse_aclr(8);
    for (int e = 1; e <= S + 3; e++) begin
      edge_model();
      obs = dut_vec();
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v || (e <= S + 1 && obs[13:10] !== 4'd0)) begin
        n_errors++;
        $display("FAIL reset_burst e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    bus.rd_req_i = 1'b0;
  endtask

  task automatic test_random();
    int occ;
    pulse_aclr(0);
    for (int c = 0; c < 600; c++) begin
      edge_model();
      obs = dut_vec();
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_v);
      end
      bus.rd_req_i = ($urandom_range(0, 99) < 45);
      occ = (m_wr - m_rd + 32) % 32;
      if (occ < 16 && $urandom_range(0, 99) < 50)
        set_wr(m_wr + 1);
    end
    bus.rd_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_read();
    test_full_wrap();
    test_reset_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
